// File: rtl/serial_display_receiver_pkg.sv
// Frame layout shared by the display bus transmitter and receiver so both ends
// agree on digit count, digit width and bit order.
package serial_display_receiver_pkg;

  localparam int DISP_DIGITS     = 4;
  localparam int DISP_SEG_BITS   = 8;
  localparam int DISP_FRAME_BITS = DISP_DIGITS * DISP_SEG_BITS;

  // The first bit on the wire is the MSB of digit 0, i.e. frame bit FRAME_BITS-1.
  typedef enum logic {
    BIT_ORDER_MSB_FIRST = 1'b0,
    BIT_ORDER_LSB_FIRST = 1'b1
  } bit_order_e;

  localparam bit_order_e DISP_BIT_ORDER = BIT_ORDER_MSB_FIRST;

  typedef logic [DISP_FRAME_BITS-1:0] disp_frame_t;

endpackage

// File: rtl/serial_sync_edge.sv
// Two-flop synchronizer with a history flop; reports the synchronized level and
// a one-cycle pulse on its rising edge.
module serial_sync_edge (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  logic [1:0] sync_q, sync_d;
  logic       hist_q, hist_d;

  always_comb begin
    sync_d = {sync_q[0], i_async};
    hist_d = sync_q[1];
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours, which is what makes this a shift chain.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign o_level = sync_q[1];
  assign o_rise  = sync_q[1] & ~hist_q;

endmodule

// File: rtl/serial_display_receiver.sv
// Receiving end of the 3-wire display bus: shifts bits on serial-clock rises and
// publishes a full-length frame on latch rises, flagging wrong-length frames.
module serial_display_receiver
  import serial_display_receiver_pkg::*;
#(
  parameter int DIGITS     = DISP_DIGITS,
  parameter int SEG_BITS   = DISP_SEG_BITS,
  parameter int FRAME_BITS = DIGITS * SEG_BITS
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_en,
  input  logic                  i_serial_data,
  input  logic                  i_serial_latch,
  input  logic                  i_serial_clk,
  input  logic                  i_clear_err,
  output logic [FRAME_BITS-1:0] o_segments,
  output logic                  o_valid,
  output logic                  o_frame_err,
  output logic [7:0]            o_frame_count
);

  localparam int                CNT_W    = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  logic data_lvl, data_rise_unused;
  logic sclk_lvl_unused, sclk_rise;
  logic latch_lvl_unused, latch_rise;

  serial_sync_edge u_sync_data (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_async(i_serial_data),
    .o_level(data_lvl), .o_rise(data_rise_unused)
  );
  serial_sync_edge u_sync_sclk (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_async(i_serial_clk),
    .o_level(sclk_lvl_unused), .o_rise(sclk_rise)
  );
  serial_sync_edge u_sync_latch (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_async(i_serial_latch),
    .o_level(latch_lvl_unused), .o_rise(latch_rise)
  );

  logic [FRAME_BITS-1:0] shreg_q, shreg_d, shreg_shift;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_shift;
  logic [FRAME_BITS-1:0] seg_q, seg_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic [7:0]            fcnt_q, fcnt_d;

  // NOTE: every signal gets a default before any branch so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    shreg_shift = shreg_q;
    cnt_shift   = cnt_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    seg_d       = seg_q;
    valid_d     = 1'b0;
    err_d       = err_q;
    fcnt_d      = fcnt_q;

    if (i_clear_err) err_d = 1'b0;

    if (i_en) begin
      // The shift is resolved first so a coincident latch sees the new bit.
      if (sclk_rise) begin
        shreg_shift = {shreg_q[FRAME_BITS-2:0], data_lvl};
        cnt_shift   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
      end
      shreg_d = shreg_shift;
      cnt_d   = cnt_shift;

      if (latch_rise) begin
        cnt_d = '0;
        if (cnt_shift == CNT_FULL) begin
          seg_d   = shreg_shift;
          valid_d = 1'b1;
          fcnt_d  = fcnt_q + 8'd1;
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      seg_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      seg_q   <= seg_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign o_segments    = seg_q;
  assign o_valid       = valid_q;
  assign o_frame_err   = err_q;
  assign o_frame_count = fcnt_q;

endmodule

// File: tb/tb_serial_display_receiver.sv
// Self-checking bench: table-driven frames, hand-written corner sequences and a
// scoreboard that matches every o_valid pulse against an expected frame.
module tb_serial_display_receiver;

  localparam int HALF = 2;  // serial half-period in i_clk cycles

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        sdata = 1'b0;
  logic        slatch = 1'b0;
  logic        sclk = 1'b0;
  logic        clear_err = 1'b0;
  logic [31:0] segments;
  logic        valid;
  logic        frame_err;
  logic [7:0]  frame_count;

  serial_display_receiver dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_en(en),
    .i_serial_data(sdata), .i_serial_latch(slatch), .i_serial_clk(sclk),
    .i_clear_err(clear_err),
    .o_segments(segments), .o_valid(valid), .o_frame_err(frame_err),
    .o_frame_count(frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] seg;
    logic [7:0]  fc;
  } sb_item_t;

  typedef struct {
    logic [63:0] val;
    int          nbits;
    logic        en;
    logic        clear_after;
    logic        exp_accept;
    logic        exp_err;
  } vec_t;

  sb_item_t    sb_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          valid_seen = 0;
  logic        prev_valid = 1'b0;
  logic [31:0] exp_seg = '0;
  logic [7:0]  exp_fc = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: each o_valid pulse must match the oldest expected frame.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid) begin
        valid_seen++;
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_valid: segments %0h with nothing expected", segments);
        end else begin
          sb_item_t it;
          it = sb_q.pop_front();
          check("sb_segments", {32'b0, segments}, {32'b0, it.seg});
          check("sb_frame_count", {56'b0, frame_count}, {56'b0, it.fc});
        end
        if (prev_valid) check("valid_width", 64'd2, 64'd1);
      end
      prev_valid = valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_bits(input logic [63:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sclk  = 1'b0;
      sdata = val[i];
      wait_cycles(HALF);
      sclk = 1'b1;
      wait_cycles(HALF);
    end
  endtask

  task automatic pulse_latch();
    sclk = 1'b0;
    wait_cycles(HALF);
    slatch = 1'b1;
    wait_cycles(HALF);
    slatch = 1'b0;
    wait_cycles(4);
  endtask

  task automatic expect_accept(input logic [31:0] seg);
    sb_item_t it;
    exp_seg = seg;
    exp_fc  = exp_fc + 8'd1;
    it.seg  = seg;
    it.fc   = exp_fc;
    sb_q.push_back(it);
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    int seen0;
    seen0 = valid_seen;
    en = v.en;
    shift_bits(v.val, v.nbits);
    if (v.exp_accept) expect_accept(v.val[31:0]);
    pulse_latch();
    en = 1'b1;
    check({tag, "_pulses"}, 64'(valid_seen - seen0), {63'b0, v.exp_accept});
    check({tag, "_segments"}, {32'b0, segments}, {32'b0, exp_seg});
    check({tag, "_err"}, {63'b0, frame_err}, {63'b0, v.exp_err});
    check({tag, "_count"}, {56'b0, frame_count}, {56'b0, exp_fc});
    if (v.clear_after) begin
      clear_err = 1'b1;
      wait_cycles(1);
      clear_err = 1'b0;
      wait_cycles(1);
      check({tag, "_cleared"}, {63'b0, frame_err}, 64'd0);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    vec_t v;

    vecs[0] = '{64'hA5C3_0F81,     32, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{64'h1234_5678,     31, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{64'hFF_DEAD_BEEF,  40, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{64'h0BAD_F00D,     32, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{64'hFFFF_FFFF,     32, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{64'h0000_0001,     32, 1'b1, 1'b0, 1'b1, 1'b0};

    wait_cycles(3);
    check("reset_segments", {32'b0, segments}, 64'd0);
    check("reset_valid", {63'b0, valid}, 64'd0);
    check("reset_err", {63'b0, frame_err}, 64'd0);
    check("reset_count", {56'b0, frame_count}, 64'd0);
    rst_n = 1'b1;
    wait_cycles(2);

    // Reset in the middle of a frame: partial bits must be forgotten.
    shift_bits(64'h3FF, 10);
    rst_n = 1'b0;
    sclk  = 1'b0;
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(2);
    v = '{64'h1234_5678, 32, 1'b1, 1'b0, 1'b1, 1'b0};
    run_frame(v, "after_reset");

    foreach (vecs[i]) run_frame(vecs[i], $sformatf("vec%0d", i));

    // Serial clock and latch rise together on the 32nd bit.
    begin
      logic [31:0] f;
      int          seen0;
      f = 32'hC0DE_5A5B;
      seen0 = valid_seen;
      shift_bits({32'b0, f} >> 1, 31);
      sclk  = 1'b0;
      sdata = f[0];
      wait_cycles(HALF);
      expect_accept(f);
      sclk   = 1'b1;
      slatch = 1'b1;
      wait_cycles(HALF);
      sclk   = 1'b0;
      slatch = 1'b0;
      wait_cycles(4);
      check("same_cycle_pulses", 64'(valid_seen - seen0), 64'd1);
      check("same_cycle_segments", {32'b0, segments}, {32'b0, f});
      check("same_cycle_err", {63'b0, frame_err}, 64'd0);
    end

    // Clear asserted in exactly the cycle the error is set: the set wins.
    shift_bits(64'h15, 5);
    sclk = 1'b0;
    wait_cycles(HALF);
    slatch = 1'b1;
    wait_cycles(2);
    clear_err = 1'b1;
    wait_cycles(1);
    clear_err = 1'b0;
    check("set_beats_clear", {63'b0, frame_err}, 64'd1);
    slatch = 1'b0;
    wait_cycles(4);
    clear_err = 1'b1;
    wait_cycles(1);
    clear_err = 1'b0;
    wait_cycles(1);
    check("clear_after_set", {63'b0, frame_err}, 64'd0);

    // Run good frames until the frame counter wraps back to zero.
    begin
      int n_wrap;
      n_wrap = 256 - int'(exp_fc);
      for (int i = 0; i < n_wrap; i++) begin
        logic [31:0] f;
        f = $urandom;
        shift_bits({32'b0, f}, 32);
        expect_accept(f);
        pulse_latch();
      end
      check("count_wrap", {56'b0, frame_count}, 64'd0);
      check("wrap_segments", {32'b0, segments}, {32'b0, exp_seg});
    end

    wait_cycles(4);
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
